// File: rtl/param_memory.sv
// Single-port byte-enabled memory with a configurable read pipeline
// and a counter-driven clear engine that zeroes the array.
module param_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic                W_R,
    input  logic [ADDR_W-1:0]   Address,
    input  logic [DATA_W-1:0]   Data_In,
    input  logic [DATA_W/8-1:0] Byte_En,
    input  logic                Clear,
    output logic [DATA_W-1:0]   Data_Out,
    output logic                Valid_Out,
    output logic                Wr_Ack,
    output logic                Busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   rd_data_q [RD_LAT];
    logic [RD_LAT-1:0]   rd_vld_q;
    logic                wr_ack_q;
    logic                acc, wr_acc, rd_acc;

    // Clear beats any request raised in the same cycle.
    assign acc    = (state_q == S_IDLE) && EN && !Clear;
    assign wr_acc = acc && W_R;
    assign rd_acc = acc && !W_R;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_IDLE: begin
                if (Clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The array has no reset; the clear engine owns its initial contents.
    always_ff @(posedge CLK) begin
        if (state_q == S_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (Byte_En[b]) begin
                    mem_q[Address][8*b +: 8] <= Data_In[8*b +: 8];
                end
            end
        end
    end

    // Stage data only moves with its valid bit, so Data_Out holds between reads.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_data_q[i] <= '0;
            end
            rd_vld_q <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            wr_ack_q    <= wr_acc;
            rd_vld_q[0] <= rd_acc;
            if (rd_acc) begin
                rd_data_q[0] <= mem_q[Address];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                if (rd_vld_q[i-1]) begin
                    rd_data_q[i] <= rd_data_q[i-1];
                end
            end
        end
    end

    assign Data_Out  = rd_data_q[RD_LAT-1];
    assign Valid_Out = rd_vld_q[RD_LAT-1];
    assign Wr_Ack    = wr_ack_q;
    assign Busy      = (state_q == S_CLEAR);

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory: a 32x16 RD_LAT=1 instance and a
// 64x64 RD_LAT=3 instance sharing clock and reset.
module tb_param_memory;

    logic clk;
    logic rst_n;

    logic        en0, wr0, clr0;
    logic [3:0]  a0, be0;
    logic [31:0] d0, q0;
    logic        v0, ack0, busy0;

    logic        en1, wr1, clr1;
    logic [5:0]  a1;
    logic [7:0]  be1;
    logic [63:0] d1, q1;
    logic        v1, ack1, busy1;

    int checks;
    int errors;

    param_memory #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1)) u0 (
        .CLK(clk), .RST(rst_n), .EN(en0), .W_R(wr0),
        .Address(a0), .Data_In(d0), .Byte_En(be0), .Clear(clr0),
        .Data_Out(q0), .Valid_Out(v0), .Wr_Ack(ack0), .Busy(busy0)
    );

    param_memory #(.DATA_W(64), .ADDR_W(6), .RD_LAT(3)) u1 (
        .CLK(clk), .RST(rst_n), .EN(en1), .W_R(wr1),
        .Address(a1), .Data_In(d1), .Byte_En(be1), .Clear(clr1),
        .Data_Out(q1), .Valid_Out(v1), .Wr_Ack(ack1), .Busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr0_t(input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        en0 = 1'b1; wr0 = 1'b1; a0 = a; d0 = d; be0 = be;
        @(negedge clk);
        en0 = 1'b0;
        check("wr0_ack", ack0, 1'b1);
    endtask

    task automatic rd0_t(input logic [3:0] a, input logic [31:0] exp);
        en0 = 1'b1; wr0 = 1'b0; a0 = a;
        @(negedge clk);
        en0 = 1'b0;
        check("rd0_vld", v0, 1'b1);
        check("rd0_data", q0, exp);
    endtask

    task automatic wr1_t(input logic [5:0] a, input logic [63:0] d,
                         input logic [7:0] be);
        en1 = 1'b1; wr1 = 1'b1; a1 = a; d1 = d; be1 = be;
        @(negedge clk);
        en1 = 1'b0;
        check("wr1_ack", ack1, 1'b1);
    endtask

    task automatic rd1_t(input logic [5:0] a, input logic [63:0] exp);
        en1 = 1'b1; wr1 = 1'b0; a1 = a;
        @(negedge clk);
        en1 = 1'b0;
        check("rd1_early0", v1, 1'b0);
        @(negedge clk);
        check("rd1_early1", v1, 1'b0);
        @(negedge clk);
        check("rd1_vld", v1, 1'b1);
        check("rd1_data", q1, exp);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        en0 = 0; wr0 = 0; clr0 = 0; a0 = '0; be0 = '0; d0 = '0;
        en1 = 0; wr1 = 0; clr1 = 0; a1 = '0; be1 = '0; d1 = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy0", busy0, 1'b1);
        check("rst_vld0", v0, 1'b0);
        check("rst_ack0", ack0, 1'b0);
        check("rst_q0", q0, 32'h0);
        check("rst_busy1", busy1, 1'b1);
        check("rst_q1", q1, 64'h0);

        // Release reset and hold a write on u0 for the whole clear.
        rst_n = 1'b1;
        en0 = 1'b1; wr0 = 1'b1; a0 = 4'd5; d0 = 32'hFFFF_FFFF; be0 = 4'hF;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (i <= 17) begin
                check("boot_busy0", busy0, i < 16);
                check("boot_ack0", ack0, 1'b0);
            end
            if (i == 16) en0 = 1'b0;
            if (i >= 62) check("boot_busy1", busy1, i < 64);
        end

        for (int a = 0; a < 16; a++) rd0_t(4'(a), 32'h0);

        wr0_t(4'd3, 32'hAABB_CCDD, 4'b1111);
        wr0_t(4'd3, 32'h1122_3344, 4'b0101);
        rd0_t(4'd3, 32'hAA22_CC44);
        @(negedge clk);
        check("hold_vld0", v0, 1'b0);
        check("hold_q0", q0, 32'hAA22_CC44);
        check("hold_ack0", ack0, 1'b0);

        wr0_t(4'd9, 32'h0000_0000, 4'b0000);
        wr0_t(4'd7, 32'h1234_5678, 4'hF);

        // Read, then Clear together with a write on the following edge.
        en0 = 1'b1; wr0 = 1'b0; a0 = 4'd7;
        @(negedge clk);
        check("pre_clr_vld", v0, 1'b1);
        check("pre_clr_data", q0, 32'h1234_5678);
        clr0 = 1'b1; en0 = 1'b1; wr0 = 1'b1; a0 = 4'd2;
        d0 = 32'hDEAD_BEEF; be0 = 4'hF;
        @(negedge clk);
        clr0 = 1'b0; en0 = 1'b0;
        check("clr_ack0", ack0, 1'b0);
        check("clr_busy0", busy0, 1'b1);
        for (int j = 1; j <= 16; j++) begin
            clr0 = (j == 5);
            @(negedge clk);
            check("clr_busy_len", busy0, j < 16);
        end
        clr0 = 1'b0;
        for (int a = 0; a < 16; a++) rd0_t(4'(a), 32'h0);

        // Wide instance: top byte lane only.
        wr1_t(6'd63, 64'hFFEE_DDCC_BBAA_9988, 8'h80);
        rd1_t(6'd63, 64'hFF00_0000_0000_0000);

        for (int a = 0; a < 4; a++) wr1_t(6'(a), 64'(8'h10 + a), 8'hFF);
        for (int i = 0; i < 8; i++) begin
            en1 = (i < 4); wr1 = 1'b0; a1 = 6'(i);
            @(negedge clk);
            check("b2b_vld", v1, (i >= 2) && (i <= 5));
            if (i < 2)
                check("b2b_q", q1, 64'hFF00_0000_0000_0000);
            else if (i <= 5)
                check("b2b_q", q1, 64'(8'h10 + i - 2));
            else
                check("b2b_q", q1, 64'h13);
        end
        en1 = 1'b0;

        // Reset lands between the accepting and the output edge.
        en1 = 1'b1; wr1 = 1'b0; a1 = 6'd1;
        @(negedge clk);
        en1 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", v1, 1'b0);
        check("mid_rst_q", q1, 64'h0);
        check("mid_rst_busy", busy1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_novld", v1, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (i >= 63) check("rerst_busy1", busy1, i < 64);
        end
        rd1_t(6'd1, 64'h0);
        rd1_t(6'd63, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
